if_fetch_ctrl: RTL and testbench

- Fetch-stage sequencer between the PC source, the ICache request/response port, and the IF check/instruction-buffer stage.
- Owns the fetch PC and issues in-order ICache reads with bounded outstanding requests.
- Pairs each returned instruction with its address and drives separate vaddr and inst valid/ready streams downstream.
- On branch, exception or ertn redirect, cancels in-flight work and silently drains stale ICache responses.

---
 rtl/if_fetch_ctrl_if.sv | 28 ++
 rtl/if_fetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// ICache request/response port and downstream vaddr/inst stream of the fetch stage.
// The fetch controller is the master; the ICache plus IF stage together form the slave.
interface if_fetch_ctrl_if;
   logic        icache_req_valid;
   logic [31:0] icache_req_addr;
   logic        icache_req_ready;
   logic        icache_rdata_valid;
   logic [31:0] icache_rdata;
   logic [31:0] vaddr;
   logic        vaddr_valid;
   logic [31:0] inst;
   logic        inst_valid;
   logic        excp_o;
   logic [3:0]  excp_num_o;
   logic        fire;

   modport master (
      output icache_req_valid, icache_req_addr, vaddr, vaddr_valid,
             inst, inst_valid, excp_o, excp_num_o,
      input  icache_req_ready, icache_rdata_valid, icache_rdata, fire
   );

   modport slave (
      input  icache_req_valid, icache_req_addr, vaddr, vaddr_valid,
             inst, inst_valid, excp_o, excp_num_o,
      output icache_req_ready, icache_rdata_valid, icache_rdata, fire
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues in-order ICache reads, pairs
// returned words with their addresses and drains stale responses after a redirect.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h1c000000,
   parameter int          MAX_OUT   = 2,
   parameter logic [3:0]  ADEF_CODE = 4'h1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [31:0] flush_target,
   input  logic        excp_flush,
   input  logic [31:0] excp_entry,
   input  logic        ertn_flush,
   input  logic [31:0] ertn_era,
   if_fetch_ctrl_if.master bus
);
   localparam int PW = $clog2(MAX_OUT);
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

   typedef enum logic {S_RUN, S_HALT} state_e;

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    cnt_q, cnt_d, infl_q, infl_d, disc_q, disc_d;
   logic [31:0]      e_pc_q   [MAX_OUT];
   logic [31:0]      e_pc_d   [MAX_OUT];
   logic [31:0]      e_inst_q [MAX_OUT];
   logic [31:0]      e_inst_d [MAX_OUT];
   logic [MAX_OUT-1:0] e_excp_q, e_excp_d, e_resp_q, e_resp_d;

   logic        any_flush, rv, req_valid, adef, req_fire, push, pop, head_has;
   logic [31:0] new_pc;
   logic        slot_found;
   logic [PW-1:0] slot_idx, scan_idx;

   assign any_flush = excp_flush | ertn_flush | flush;
   assign new_pc    = excp_flush ? excp_entry : (ertn_flush ? ertn_era : flush_target);
   assign rv        = bus.icache_rdata_valid;
   assign head_has  = (cnt_q != '0) && e_resp_q[head_q];
   assign req_fire  = req_valid & bus.icache_req_ready;
   assign push      = req_fire | adef;
   assign pop       = bus.fire & head_has;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_RUN;
      else       state_q <= state_d;
   end

   // FSM: next state; any redirect resumes fetch, a misaligned PC parks it
   always_comb begin
      state_d = state_q;
      if (any_flush)                     state_d = S_RUN;
      else if (state_q == S_RUN && adef) state_d = S_HALT;
   end

   // FSM: outputs
   always_comb begin
      req_valid = 1'b0;
      adef      = 1'b0;
      case (state_q)
         S_RUN: begin
            req_valid = !reset && !any_flush && pc_q[1:0] == 2'b00 &&
                        cnt_q < CNT_MAX && infl_q < CNT_MAX;
            adef      = !reset && !any_flush && pc_q[1:0] != 2'b00 && cnt_q < CNT_MAX;
         end
         default: ;
      endcase
   end

   // Oldest queued entry still waiting for its ICache word
   always_comb begin
      slot_found = 1'b0;
      slot_idx   = '0;
      scan_idx   = '0;
      for (int i = 0; i < MAX_OUT; i++) begin
         scan_idx = head_q + PW'(i);
         if (!slot_found && CW'(i) < cnt_q && !e_resp_q[scan_idx]) begin
            slot_found = 1'b1;
            slot_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      pc_d     = pc_q;
      head_d   = head_q;
      tail_d   = tail_q;
      cnt_d    = cnt_q;
      infl_d   = infl_q;
      disc_d   = disc_q;
      e_pc_d   = e_pc_q;
      e_inst_d = e_inst_q;
      e_excp_d = e_excp_q;
      e_resp_d = e_resp_q;
      if (any_flush) begin
         // Every request still outstanding after this cycle becomes stale.
         pc_d     = new_pc;
         head_d   = '0;
         tail_d   = '0;
         cnt_d    = '0;
         e_resp_d = '0;
         infl_d   = infl_q - CW'(rv);
         disc_d   = infl_q - CW'(rv);
      end else begin
         if (push) begin
            e_pc_d[tail_q]   = pc_q;
            e_excp_d[tail_q] = adef;
            e_resp_d[tail_q] = adef;
            e_inst_d[tail_q] = '0;
            tail_d           = tail_q + PW'(1);
         end
         if (req_fire) pc_d = pc_q + 32'd4;
         if (rv) begin
            if (disc_q != '0) begin
               disc_d = disc_q - CW'(1);
            end else if (slot_found) begin
               e_resp_d[slot_idx] = 1'b1;
               e_inst_d[slot_idx] = bus.icache_rdata;
            end
         end
         if (pop) begin
            head_d           = head_q + PW'(1);
            e_resp_d[head_q] = 1'b0;
         end
         infl_d = infl_q + CW'(req_fire) - CW'(rv);
         cnt_d  = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         head_q   <= '0;
         tail_q   <= '0;
         cnt_q    <= '0;
         infl_q   <= '0;
         disc_q   <= '0;
         e_excp_q <= '0;
         e_resp_q <= '0;
      end else begin
         pc_q     <= pc_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         cnt_q    <= cnt_d;
         infl_q   <= infl_d;
         disc_q   <= disc_d;
         e_excp_q <= e_excp_d;
         e_resp_q <= e_resp_d;
      end
   end

   // Payload storage needs no reset: it is only visible behind the valid flags.
   always_ff @(posedge clk) begin
      e_pc_q   <= e_pc_d;
      e_inst_q <= e_inst_d;
   end

   assign bus.icache_req_valid = req_valid;
   assign bus.icache_req_addr  = pc_q;
   assign bus.vaddr_valid      = cnt_q != '0;
   assign bus.vaddr            = bus.vaddr_valid ? e_pc_q[head_q] : '0;
   assign bus.inst_valid       = head_has;
   assign bus.inst             = head_has ? e_inst_q[head_q] : '0;
   assign bus.excp_o           = bus.vaddr_valid & e_excp_q[head_q];
   assign bus.excp_num_o       = bus.excp_o ? ADEF_CODE : 4'h0;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench: an in-order ICache model plus a queue-level reference of the
// fetch controller; every DUT output is compared each cycle.
module tb_if_fetch_ctrl;
   localparam logic [31:0] RESET_PC = 32'h1c000000;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush, excp_flush, ertn_flush;
   logic [31:0] flush_target, excp_entry, ertn_era;

   if_fetch_ctrl_if bus();

   if_fetch_ctrl #(.RESET_PC(RESET_PC), .MAX_OUT(2), .ADEF_CODE(4'h1)) dut (
      .clk(clk), .reset(reset),
      .flush(flush), .flush_target(flush_target),
      .excp_flush(excp_flush), .excp_entry(excp_entry),
      .ertn_flush(ertn_flush), .ertn_era(ertn_era),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; bit excp; bit has; logic [31:0] inst; } ent_t;
   typedef struct { logic [31:0] addr; bit stale; } req_t;

   ent_t        mq[$];   // issued-but-unconsumed entries, oldest first
   req_t        ic[$];   // requests the ICache still owes a response for
   logic [31:0] m_pc;
   bit          m_halt;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5a3c9617;
   endfunction

   function automatic logic [31:0] rnd_target();
      logic [9:0] mid;
      logic [1:0] lo;
      int sel;
      mid = 10'($urandom);
      lo  = 2'($urandom_range(3, 1));
      sel = $urandom_range(7);
      if (sel == 0) return {20'h1c000, mid, lo};
      if (sel == 1) return 32'hfffffff8;
      return {20'h1c000, mid, 2'b00};
   endfunction

   task automatic model_reset();
      mq.delete();
      ic.delete();
      m_pc   = RESET_PC;
      m_halt = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      flush = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0;
      bus.icache_rdata_valid = 1'b0;
      bus.icache_req_ready   = 1'b1;
      bus.fire               = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_req_valid",   bus.icache_req_valid, 0);
      chk("rst_req_addr",    bus.icache_req_addr,  RESET_PC);
      chk("rst_vaddr_valid", bus.vaddr_valid,      0);
      chk("rst_vaddr",       bus.vaddr,            0);
      chk("rst_inst_valid",  bus.inst_valid,       0);
      chk("rst_inst",        bus.inst,             0);
      chk("rst_excp",        bus.excp_o,           0);
      chk("rst_excp_num",    bus.excp_num_o,       0);
      model_reset();
      @(posedge clk); #1;
   endtask

   // One cycle: drive random inputs, check outputs against the model, advance the model.
   task automatic step(input int p_rdy, input int p_rv, input int p_fire, input int p_fl);
      bit ef, rf, bf, rv, fi, any, req, adef;
      logic [31:0] npc;
      req_t r;
      reset = 1'b0;
      ef = $urandom_range(99) < p_fl;
      rf = $urandom_range(99) < p_fl;
      bf = $urandom_range(99) < p_fl;
      excp_flush = ef; ertn_flush = rf; flush = bf;
      excp_entry = rnd_target(); ertn_era = rnd_target(); flush_target = rnd_target();
      rv = ic.size() > 0 && $urandom_range(99) < p_rv;
      bus.icache_rdata_valid = rv;
      bus.icache_rdata       = rv ? mem_word(ic[0].addr) : $urandom;
      bus.icache_req_ready   = $urandom_range(99) < p_rdy;
      fi = mq.size() > 0 && mq[0].has && $urandom_range(99) < p_fire;
      bus.fire = fi;
      @(negedge clk);

      any  = ef | rf | bf;
      npc  = ef ? excp_entry : (rf ? ertn_era : flush_target);
      req  = !m_halt && !any && m_pc[1:0] == 2'b00 && mq.size() < 2 && ic.size() < 2;
      adef = !m_halt && !any && m_pc[1:0] != 2'b00 && mq.size() < 2;
      chk("req_valid",   bus.icache_req_valid, req);
      chk("req_addr",    bus.icache_req_addr,  m_pc);
      chk("vaddr_valid", bus.vaddr_valid,      mq.size() > 0);
      if (mq.size() > 0) begin
         chk("vaddr",      bus.vaddr,      mq[0].pc);
         chk("inst_valid", bus.inst_valid, mq[0].has);
         chk("excp_o",     bus.excp_o,     mq[0].excp);
         chk("excp_num",   bus.excp_num_o, mq[0].excp ? 4'h1 : 4'h0);
         if (mq[0].has) chk("inst", bus.inst, mq[0].inst);
      end else begin
         chk("inst_valid_empty", bus.inst_valid, 0);
      end

      if (any) begin
         if (rv) void'(ic.pop_front());
         foreach (ic[k]) ic[k].stale = 1;
         mq.delete();
         m_pc   = npc;
         m_halt = 0;
      end else begin
         if (rv) begin
            r = ic.pop_front();
            if (!r.stale) begin
               for (int k = 0; k < mq.size(); k++) begin
                  if (!mq[k].has) begin
                     mq[k].has  = 1;
                     mq[k].inst = mem_word(r.addr);
                     break;
                  end
               end
            end
         end
         if (fi) void'(mq.pop_front());
         if (req && bus.icache_req_ready) begin
            mq.push_back('{pc: m_pc, excp: 1'b0, has: 1'b0, inst: 32'h0});
            ic.push_back('{addr: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
         end
         if (adef) begin
            mq.push_back('{pc: m_pc, excp: 1'b1, has: 1'b1, inst: 32'h0});
            m_halt = 1;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0;
      flush_target = '0; excp_entry = '0; ertn_era = '0;
      bus.icache_req_ready = 1'b0; bus.icache_rdata_valid = 1'b0;
      bus.icache_rdata = '0; bus.fire = 1'b0;
      do_reset();
      repeat (40)  step(100, 100, 100, 0);   // streaming
      repeat (20)  step(100, 100,   0, 0);   // downstream stalled
      repeat (20)  step(100, 100, 100, 0);   // release
      step(100, 100, 100, 100);              // all three redirects together
      repeat (300) step(70, 50, 60, 6);
      repeat (3)   step(80, 80, 80, 0);
      do_reset();                            // reset mid-operation
      repeat (300) step(50, 70, 40, 10);
      repeat (200) step(90, 30, 90, 4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
